tw_sequencer: RTL and testbench
===============================

TW_SEQUENCER -- requirements
Module: tw_sequencer

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 9, the register address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, the register data width.
REQ-003 SHALL have parameter DEPTH, default 4, the command FIFO depth; only powers of 2 are legal.
REQ-004 SHALL have parameter START_TIMEOUT, default 8, the maximum cycles to wait for busy after start.
REQ-005 Ports, as name / direction / width / meaning:
- in_clk / in / 1 / the single clock; all logic is on its rising edge.
- in_rst / in / 1 / reset, synchronous and active-high.
- in_cmd_valid / in / 1 / command offered.
- out_cmd_ready / out / 1 / FIFO can accept a command.
- in_cmd_write / in / 1 / 1 = write, 0 = read.
- in_cmd_addr / in / ADDR_BITS / register address.
- in_cmd_wdata / in / DATA_BITS / write data; ignored for reads.
- out_rsp_valid / out / 1 / read response available.
- in_rsp_ready / in / 1 / response consumer ready.
- out_rsp_addr / out / ADDR_BITS / address of the response.
- out_rsp_data / out / DATA_BITS / read data.
- out_tw_start / out / 1 / start pulse to the threewire master.
- out_tw_r_w / out / 1 / to the master in_r_w; 1 = write.
- out_tw_addr / out / ADDR_BITS / to the master in_addr.
- out_tw_wr_data / out / DATA_BITS / to the master in_wr_data.
- in_tw_rd_data / in / DATA_BITS / from the master out_rd_data.
- in_tw_busy / in / 1 / from the master out_io_in_progress.
- out_fifo_level / out / log2(DEPTH)+1 / number of queued commands.
- out_timeout_err / out / 1 / sticky start-timeout flag.
- out_idle / out / 1 / FIFO empty, FSM in IDLE, no response pending.

Function
REQ-006 FIFO: {write, addr, wdata} pushed on an edge where in_cmd_valid && out_cmd_ready.
REQ-007 out_cmd_ready = level < DEPTH; a command offered while full is not accepted and is not lost (the source holds it).
REQ-008 FIFO order is strict first-in-first-out; pointers wrap modulo DEPTH; push and pop on the same edge leave the level unchanged.
REQ-009 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-010 IDLE: if the FIFO is non-empty, pop the head into the out_tw_* registers and go to ISSUE on the same edge; otherwise stay in IDLE.
REQ-011 ISSUE: out_tw_start=1 for exactly this one cycle, then go to WAIT_BUSY.
- out_tw_start is registered from state.
- For a command accepted at edge E into an empty FIFO with the FSM in IDLE, the pop occurs at E+1 and start is high from E+2 to E+3.
REQ-012 WAIT_BUSY: on in_tw_busy=1, go to WAIT_DONE.
- Otherwise increment the timeout counter.
- When the counter reaches START_TIMEOUT, set out_timeout_err, discard the command and go to IDLE; no response is produced.
REQ-013 WAIT_DONE: on in_tw_busy=0:
- for a read, capture in_tw_rd_data and the address into the out_rsp_* registers and go to RESP;
- for a write, go to IDLE.
REQ-014 RESP: out_rsp_valid=1 and out_rsp_* held stable until an edge with in_rsp_ready=1, then go to IDLE; no new command is popped while in RESP.
REQ-015 out_tw_r_w, out_tw_addr and out_tw_wr_data SHALL remain stable from ISSUE until the FSM leaves WAIT_DONE.
REQ-016 out_timeout_err SHALL be sticky; only reset clears it.
REQ-017 The FIFO accepts pushes in every FSM state, including RESP.

Reset
REQ-018 in_rst=1 at an edge SHALL:
- flush the FIFO (level 0, out_cmd_ready=1 after reset);
- put the FSM in IDLE;
- force out_tw_start, out_rsp_valid and out_timeout_err to 0;
- zero the timeout counter, out_tw_* and out_rsp_*;
- force out_idle=1.
REQ-019 Reset mid-transfer abandons the command without a response; the master shares in_rst and is reset alongside.
REQ-020 While in_rst=1, no command is accepted.

Verification
REQ-021 Read: read addr 0x155; the model master asserts busy 2 cycles after start and returns 0x96CA -> exactly one start pulse, out_tw_r_w=0, out_tw_addr=0x155, then rsp_valid with addr 0x155 and data 0x96CA.
REQ-022 Write: write addr 0x1B2, data 0xA4F9 -> out_tw_r_w=1 and out_tw_wr_data=0xA4F9 stable through busy; no response; out_idle=1 afterwards.
REQ-023 Full: 6 back-to-back commands with the master stalled busy -> level reaches 4 with ready=0 (one command popped into the FSM); all 6 execute in order.
REQ-024 Backpressure: 2 reads with in_rsp_ready=0 for 20 cycles -> the first response is held and the second start is not issued until the handshake completes.
REQ-025 Timeout: the master never asserts busy -> out_timeout_err=1 exactly START_TIMEOUT cycles into WAIT_BUSY; the next queued command still executes; the flag clears only on reset.
REQ-026 Reset in WAIT_DONE with 3 commands queued -> level 0, start=0, rsp_valid=0 on the next cycle; no stale response appears afterwards.

Source files
------------

// File: rtl/tw_sequencer.sv
// tw_sequencer: queues register read/write commands in a small FIFO and
// plays them one at a time into a threewire master, waiting for the
// master's busy window and returning read data on a response channel.
module tw_sequencer #(
    parameter int ADDR_BITS     = 9,
    parameter int DATA_BITS     = 16,
    parameter int DEPTH         = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                       in_clk,
    input  logic                       in_rst,
    input  logic                       in_cmd_valid,
    output logic                       out_cmd_ready,
    input  logic                       in_cmd_write,
    input  logic [ADDR_BITS-1:0]       in_cmd_addr,
    input  logic [DATA_BITS-1:0]       in_cmd_wdata,
    output logic                       out_rsp_valid,
    input  logic                       in_rsp_ready,
    output logic [ADDR_BITS-1:0]       out_rsp_addr,
    output logic [DATA_BITS-1:0]       out_rsp_data,
    output logic                       out_tw_start,
    output logic                       out_tw_r_w,
    output logic [ADDR_BITS-1:0]       out_tw_addr,
    output logic [DATA_BITS-1:0]       out_tw_wr_data,
    input  logic [DATA_BITS-1:0]       in_tw_rd_data,
    input  logic                       in_tw_busy,
    output logic [$clog2(DEPTH):0]     out_fifo_level,
    output logic                       out_timeout_err,
    output logic                       out_idle
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);

    typedef struct packed {
        logic                 write;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t            state;
    cmd_t              mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [TO_W-1:0]   to_cnt;
    logic              push;
    logic              pop;
    cmd_t              cmd_in;
    cmd_t              head;

    // Pointer advance that also works when DEPTH is not a full pointer range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Accept only outside reset so a command held across reset is never taken.
    assign out_cmd_ready = !in_rst && (out_fifo_level < LVL_W'(DEPTH));
    assign push          = in_cmd_valid && out_cmd_ready;
    assign pop           = (state == S_IDLE) && (out_fifo_level != '0);
    assign cmd_in        = '{write: in_cmd_write, addr: in_cmd_addr, wdata: in_cmd_wdata};
    assign head          = mem[rd_ptr];
    assign out_idle      = (out_fifo_level == '0) && (state == S_IDLE) && !out_rsp_valid;

    // FIFO storage: plain memory, no reset needed since level gates reads.
    always_ff @(posedge in_clk) begin
        if (push) mem[wr_ptr] <= cmd_in;
    end

    // FIFO pointers and occupancy; simultaneous push/pop keeps level steady.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            out_fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   out_fifo_level <= out_fifo_level + 1'b1;
                2'b01:   out_fifo_level <= out_fifo_level - 1'b1;
                default: out_fifo_level <= out_fifo_level;
            endcase
        end
    end

    // Sequencing FSM; the start pulse is a registered copy of the ISSUE state.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state           <= S_IDLE;
            to_cnt          <= '0;
            out_tw_start    <= 1'b0;
            out_tw_r_w      <= 1'b0;
            out_tw_addr     <= '0;
            out_tw_wr_data  <= '0;
            out_rsp_valid   <= 1'b0;
            out_rsp_addr    <= '0;
            out_rsp_data    <= '0;
            out_timeout_err <= 1'b0;
        end else begin
            out_tw_start <= (state == S_ISSUE);
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        out_tw_r_w     <= head.write;
                        out_tw_addr    <= head.addr;
                        out_tw_wr_data <= head.wdata;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (in_tw_busy) begin
                        state <= S_WAIT_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        // Master never answered: drop the command, flag it.
                        if (to_cnt == TO_W'(START_TIMEOUT - 1)) begin
                            out_timeout_err <= 1'b1;
                            state           <= S_IDLE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!in_tw_busy) begin
                        if (!out_tw_r_w) begin
                            out_rsp_valid <= 1'b1;
                            out_rsp_addr  <= out_tw_addr;
                            out_rsp_data  <= in_tw_rd_data;
                            state         <= S_RESP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RESP: begin
                    if (in_rsp_ready) begin
                        out_rsp_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tw_sequencer.sv
// tb_tw_sequencer: directed vectors plus multi-cycle corner sequences
// against a small threewire master model.
module tb_tw_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [8:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [8:0]  rsp_addr;
    logic [15:0] rsp_data;
    logic        tw_start;
    logic        tw_r_w;
    logic [8:0]  tw_addr;
    logic [15:0] tw_wr_data;
    logic [15:0] tw_rd_data;
    logic        tw_busy;
    logic [2:0]  fifo_level;
    logic        timeout_err;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // master model controls
    logic stall = 1'b0;
    logic never_busy = 1'b0;
    int   m_ph = 0;
    int   m_cnt = 0;
    int   stab_err = 0;

    typedef struct {
        logic        w;
        logic [8:0]  a;
        logic [15:0] d;
        int          c;
    } st_t;
    typedef struct {
        logic [8:0]  a;
        logic [15:0] d;
    } rs_t;
    st_t st_log[$];
    rs_t rs_log[$];

    logic        rsp_hold = 1'b0;
    logic [8:0]  h_addr = '0;
    logic [15:0] h_data = '0;

    tw_sequencer dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_cmd_valid   (cmd_valid),
        .out_cmd_ready  (cmd_ready),
        .in_cmd_write   (cmd_write),
        .in_cmd_addr    (cmd_addr),
        .in_cmd_wdata   (cmd_wdata),
        .out_rsp_valid  (rsp_valid),
        .in_rsp_ready   (rsp_ready),
        .out_rsp_addr   (rsp_addr),
        .out_rsp_data   (rsp_data),
        .out_tw_start   (tw_start),
        .out_tw_r_w     (tw_r_w),
        .out_tw_addr    (tw_addr),
        .out_tw_wr_data (tw_wr_data),
        .in_tw_rd_data  (tw_rd_data),
        .in_tw_busy     (tw_busy),
        .out_fifo_level (fifo_level),
        .out_timeout_err(timeout_err),
        .out_idle       (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rd_map(input logic [8:0] a);
        if (a == 9'h155) return 16'h96CA;
        return {7'd0, a} ^ 16'h5A5A;
    endfunction

    // Master model: busy rises 2 cycles after start, lasts 3 cycles (or while stalled).
    always @(posedge clk) begin
        if (rst) begin
            tw_busy    <= 1'b0;
            tw_rd_data <= '0;
            m_ph       <= 0;
            m_cnt      <= 0;
        end else begin
            case (m_ph)
                0: if (tw_start && !never_busy) m_ph <= 1;
                1: begin
                    tw_busy    <= 1'b1;
                    tw_rd_data <= tw_r_w ? 16'h0000 : rd_map(tw_addr);
                    m_cnt      <= 0;
                    m_ph       <= 2;
                end
                default: begin
                    if (!stall && m_cnt >= 2) begin
                        tw_busy <= 1'b0;
                        m_ph    <= 0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            endcase
        end
    end

    // Monitor: log starts and response handshakes, watch stability.
    always @(negedge clk) begin
        if (tw_start) st_log.push_back('{w: tw_r_w, a: tw_addr, d: tw_wr_data, c: cyc});
        if (rsp_valid && rsp_ready) rs_log.push_back('{a: rsp_addr, d: rsp_data});
        if (tw_busy && st_log.size() > 0) begin
            if (tw_r_w != st_log[$].w || tw_addr != st_log[$].a || tw_wr_data != st_log[$].d)
                stab_err <= stab_err + 1;
        end
        if (rsp_valid && rsp_hold && (rsp_addr != h_addr || rsp_data != h_data))
            stab_err <= stab_err + 1;
        rsp_hold <= rsp_valid && !rsp_ready && !rst;
        h_addr   <= rsp_addr;
        h_data   <= rsp_data;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_cmd(input logic w, input logic [8:0] a, input logic [15:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("push_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(idle && !tw_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("wait_idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic        exp_rsp;
        logic [15:0] exp_data;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int sb, rb, acc, n;
        logic [8:0]  fa[6];
        logic        fw[6];
        logic [15:0] fd[6];

        vecs[0] = '{wr: 1'b0, addr: 9'h155, wdata: 16'h0000, exp_rsp: 1'b1, exp_data: 16'h96CA};
        vecs[1] = '{wr: 1'b1, addr: 9'h1B2, wdata: 16'hA4F9, exp_rsp: 1'b0, exp_data: 16'h0000};
        vecs[2] = '{wr: 1'b0, addr: 9'h000, wdata: 16'h1234, exp_rsp: 1'b1, exp_data: 16'h5A5A};
        vecs[3] = '{wr: 1'b0, addr: 9'h1FF, wdata: 16'h0000, exp_rsp: 1'b1, exp_data: 16'h5BA5};
        vecs[4] = '{wr: 1'b1, addr: 9'h000, wdata: 16'hFFFF, exp_rsp: 1'b0, exp_data: 16'h0000};

        // reset, with a command offered throughout
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h0AA; cmd_wdata = 16'h5555;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_start", 32'(tw_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_tw_addr", 32'(tw_addr), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_no_accept", 32'(st_log.size()), 32'd0);

        // table vectors: one command each
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb = st_log.size();
            rb = rs_log.size();
            @(posedge clk); #1;
            push_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            acc = cyc;
            wait_idle(100);
            check($sformatf("v%0d_starts", i), 32'(st_log.size() - sb), 32'd1);
            if (st_log.size() > sb) begin
                check($sformatf("v%0d_latency", i), 32'(st_log[sb].c - acc), 32'd2);
                check($sformatf("v%0d_r_w", i), 32'(st_log[sb].w), 32'(vecs[i].wr));
                check($sformatf("v%0d_addr", i), 32'(st_log[sb].a), 32'(vecs[i].addr));
                if (vecs[i].wr)
                    check($sformatf("v%0d_wdata", i), 32'(st_log[sb].d), 32'(vecs[i].wdata));
            end
            check($sformatf("v%0d_rsp_cnt", i), 32'(rs_log.size() - rb), 32'(vecs[i].exp_rsp));
            if (vecs[i].exp_rsp && rs_log.size() > rb) begin
                check($sformatf("v%0d_rsp_addr", i), 32'(rs_log[rb].a), 32'(vecs[i].addr));
                check($sformatf("v%0d_rsp_data", i), 32'(rs_log[rb].d), 32'(vecs[i].exp_data));
            end
            check($sformatf("v%0d_idle", i), 32'(idle), 32'd1);
        end
        check("stable_after_vectors", 32'(stab_err), 32'd0);

        // full FIFO with the master stalled
        fw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        fa = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014, 9'h015};
        fd = '{16'h1111, 16'h0000, 16'h2222, 16'h0000, 16'h3333, 16'h0000};
        sb = st_log.size();
        rb = rs_log.size();
        stall = 1'b1;
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 6; k++) push_cmd(fw[k], fa[k], fd[k]);
            end
            begin
                repeat (15) @(negedge clk);
                check("full_level", 32'(fifo_level), 32'd4);
                check("full_ready", 32'(cmd_ready), 32'd0);
                check("full_starts", 32'(st_log.size() - sb), 32'd1);
                @(posedge clk); #1 stall = 1'b0;
            end
        join
        wait_idle(400);
        check("full_total_starts", 32'(st_log.size() - sb), 32'd6);
        if (st_log.size() - sb == 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("full_order_addr%0d", k), 32'(st_log[sb + k].a), 32'(fa[k]));
                check($sformatf("full_order_rw%0d", k), 32'(st_log[sb + k].w), 32'(fw[k]));
            end
        end
        check("full_rsp_cnt", 32'(rs_log.size() - rb), 32'd3);
        if (rs_log.size() - rb == 3) begin
            check("full_rsp0", {7'd0, rs_log[rb].a, rs_log[rb].d}, {7'd0, 9'h011, 16'h5A4B});
            check("full_rsp1", {7'd0, rs_log[rb + 1].a, rs_log[rb + 1].d}, {7'd0, 9'h013, 16'h5A49});
            check("full_rsp2", {7'd0, rs_log[rb + 2].a, rs_log[rb + 2].d}, {7'd0, 9'h015, 16'h5A4F});
        end

        // response backpressure
        sb = st_log.size();
        rb = rs_log.size();
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        push_cmd(1'b0, 9'h020, 16'h0000);
        push_cmd(1'b0, 9'h021, 16'h0000);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        push_cmd(1'b1, 9'h022, 16'hBEEF);
        @(negedge clk);
        check("bp_push_in_resp", 32'(fifo_level), 32'd2);
        repeat (20) @(negedge clk);
        check("bp_starts_held", 32'(st_log.size() - sb), 32'd1);
        check("bp_valid_held", 32'(rsp_valid), 32'd1);
        check("bp_addr_held", 32'(rsp_addr), 32'h020);
        check("bp_data_held", 32'(rsp_data), 32'h5A7A);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_idle(200);
        check("bp_total_starts", 32'(st_log.size() - sb), 32'd3);
        check("bp_rsp_cnt", 32'(rs_log.size() - rb), 32'd2);
        if (rs_log.size() - rb == 2) begin
            check("bp_rsp0", {7'd0, rs_log[rb].a, rs_log[rb].d}, {7'd0, 9'h020, 16'h5A7A});
            check("bp_rsp1", {7'd0, rs_log[rb + 1].a, rs_log[rb + 1].d}, {7'd0, 9'h021, 16'h5A7B});
        end
        check("bp_stable", 32'(stab_err), 32'd0);

        // start timeout
        sb = st_log.size();
        rb = rs_log.size();
        never_busy = 1'b1;
        @(posedge clk); #1;
        push_cmd(1'b0, 9'h030, 16'h0000);
        push_cmd(1'b1, 9'h031, 16'hDEAD);
        n = 0;
        while (!timeout_err && n < 100) begin @(negedge clk); n++; end
        never_busy = 1'b0;
        check("to_flag_set", 32'(timeout_err), 32'd1);
        if (st_log.size() > sb)
            check("to_delay", 32'(cyc - st_log[sb].c), 32'd8);
        wait_idle(200);
        check("to_starts", 32'(st_log.size() - sb), 32'd2);
        if (st_log.size() - sb == 2) begin
            check("to_next_addr", 32'(st_log[sb + 1].a), 32'h031);
            check("to_next_rw", 32'(st_log[sb + 1].w), 32'd1);
        end
        check("to_no_rsp", 32'(rs_log.size() - rb), 32'd0);
        check("to_sticky", 32'(timeout_err), 32'd1);
        do_reset(2);
        @(negedge clk);
        check("to_cleared", 32'(timeout_err), 32'd0);

        // reset during WAIT_DONE with three commands queued
        stall = 1'b1;
        @(posedge clk); #1;
        push_cmd(1'b0, 9'h040, 16'h0000);
        push_cmd(1'b0, 9'h041, 16'h0000);
        push_cmd(1'b1, 9'h042, 16'h4242);
        push_cmd(1'b0, 9'h043, 16'h0000);
        n = 0;
        while (!tw_busy && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("rwd_level_before", 32'(fifo_level), 32'd3);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("rwd_level", 32'(fifo_level), 32'd0);
        check("rwd_start", 32'(tw_start), 32'd0);
        check("rwd_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rwd_idle", 32'(idle), 32'd1);
        sb = st_log.size();
        rb = rs_log.size();
        repeat (30) @(negedge clk);
        check("rwd_no_start", 32'(st_log.size() - sb), 32'd0);
        check("rwd_no_rsp", 32'(rs_log.size() - rb), 32'd0);
        check("rwd_still_idle", 32'(idle), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
